// File: rtl/search_controller.sv
// Brute-force password search sequencer: steps a packed-BCD candidate past the decoder
// and latches the first hit. Define SEARCH_CTRL_STATS_EN to build the BCD attempt counter.
module search_controller #(
  parameter int PASSLEN = 5,
  parameter int ATT_DIG = 12
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic                   ABORT,
  input  logic                   ACK,
  input  logic [8*PASSLEN-1:0]   START_VAL,
  input  logic [8*PASSLEN-1:0]   END_VAL,
  input  logic                   FOUND,
  output logic [8*PASSLEN-1:0]   CAND,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   HIT,
  output logic [8*PASSLEN-1:0]   RESULT,
  output logic                   ERR,
  output logic [4*ATT_DIG-1:0]   ATTEMPTS
);

  localparam int CAND_DIG = 2 * PASSLEN;

  typedef enum logic [1:0] {IDLE, RUN, S_HIT, S_MISS} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   args_ok;
  logic                   start_ok;
  logic                   cand_carry;
  logic [8*PASSLEN-1:0]   cand_inc;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    args_ok = 1'b1;
    for (int i = 0; i < CAND_DIG; i++) begin
      if (START_VAL[4*i +: 4] > 4'd9 || END_VAL[4*i +: 4] > 4'd9) args_ok = 1'b0;
    end

    // Digit-serial decimal increment; all-9s rolls over to all-0s.
    cand_inc   = CAND;
    cand_carry = 1'b1;
    for (int i = 0; i < CAND_DIG; i++) begin
      if (cand_carry) begin
        if (CAND[4*i +: 4] == 4'd9) begin
          cand_inc[4*i +: 4] = 4'd0;
        end else begin
          cand_inc[4*i +: 4] = CAND[4*i +: 4] + 4'd1;
          cand_carry         = 1'b0;
        end
      end
    end
  end

  // START is only honoured outside RUN; a rejected START leaves the state alone.
  assign start_ok = (state != RUN) && START && args_ok;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (ABORT)                state_nxt = IDLE;
        else if (FOUND)           state_nxt = S_HIT;
        else if (CAND == END_VAL) state_nxt = S_MISS;
      end
      default: begin
        if (start_ok)                   state_nxt = RUN;
        else if (ACK && state != IDLE)  state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      CAND   <= '0;
      RESULT <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      HIT    <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      state <= state_nxt;
      BUSY  <= (state_nxt == RUN);
      DONE  <= (state_nxt == S_HIT) || (state_nxt == S_MISS);
      HIT   <= (state_nxt == S_HIT);
      ERR   <= (state != RUN) && START && !args_ok;

      if (start_ok) begin
        CAND   <= START_VAL;
        RESULT <= '0;
      end else if (state == RUN && !ABORT) begin
        if (FOUND)                RESULT <= CAND;
        else if (CAND != END_VAL) CAND   <= cand_inc;
      end
    end
  end

`ifdef SEARCH_CTRL_STATS_EN
  logic                 att_carry;
  logic                 att_sat;
  logic [4*ATT_DIG-1:0] att_inc;

  always_comb begin
    att_sat   = 1'b1;
    att_inc   = ATTEMPTS;
    att_carry = 1'b1;
    for (int i = 0; i < ATT_DIG; i++) begin
      if (ATTEMPTS[4*i +: 4] != 4'd9) att_sat = 1'b0;
      if (att_carry) begin
        if (ATTEMPTS[4*i +: 4] == 4'd9) begin
          att_inc[4*i +: 4] = 4'd0;
        end else begin
          att_inc[4*i +: 4] = ATTEMPTS[4*i +: 4] + 4'd1;
          att_carry         = 1'b0;
        end
      end
    end
  end

  // Every RUN cycle that is not aborted tests one candidate; the count sticks at all-9s.
  always_ff @(posedge CLK) begin
    if (RST)                                     ATTEMPTS <= '0;
    else if (start_ok)                           ATTEMPTS <= '0;
    else if (state == RUN && !ABORT && !att_sat) ATTEMPTS <= att_inc;
  end
`else
  assign ATTEMPTS = '0;
`endif

endmodule

// File: tb/tb_search_controller.sv
// Self-checking bench for search_controller (PASSLEN=2): directed cases plus randomized
// searches compared against an integer-domain model of the search.
module tb_search_controller;

  localparam int PL = 2;
  localparam int AD = 12;

  logic             clk = 1'b0;
  logic             rst, start, abort, ack;
  logic [8*PL-1:0]  start_val, end_val, cand, result;
  logic             found, busy, done, hit, err;
  logic [4*AD-1:0]  attempts;
  logic [8*PL-1:0]  target = 16'h0042;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  assign found = (cand == target);

  search_controller #(.PASSLEN(PL), .ATT_DIG(AD)) dut (
    .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .ACK(ack),
    .START_VAL(start_val), .END_VAL(end_val), .FOUND(found),
    .CAND(cand), .BUSY(busy), .DONE(done), .HIT(hit), .RESULT(result),
    .ERR(err), .ATTEMPTS(attempts)
  );

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int v;
    v = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    int r;
    r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [4*AD-1:0] exp_attempts(input int n);
    logic [4*AD-1:0] r;
    int v;
    r = '0;
    v = n;
`ifdef SEARCH_CTRL_STATS_EN
    for (int i = 0; i < AD; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
`endif
    return r;
  endfunction

  // Walks the candidate space as plain integers mod 10000.
  task automatic model_search(input int s, input int e, input int t,
                              output bit m_hit, output int m_cnt, output int m_final);
    int n;
    n = s; m_cnt = 0; m_hit = 0; m_final = s;
    for (int k = 0; k <= 10000; k++) begin
      m_cnt++;
      if (n == t) begin m_hit = 1; m_final = n; break; end
      if (n == e) begin m_hit = 0; m_final = n; break; end
      n = (n + 1) % 10000;
    end
  endtask

  task automatic run_search(input logic [15:0] sv, input logic [15:0] ev, input bit do_ack,
                            input string name);
    bit m_hit; int m_cnt, m_final, s;
    s = from_bcd(sv);
    model_search(s, from_bcd(ev), from_bcd(target), m_hit, m_cnt, m_final);
    @(negedge clk);
    start = 1'b1; start_val = sv; end_val = ev;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < m_cnt; j++) begin
      tests++;
      if (cand !== to_bcd((s + j) % 10000) || busy !== 1'b1 || done !== 1'b0) begin
        failed++;
        $display("FAIL %s run cycle %0d: cand=%h busy=%b done=%b, expected cand=%h busy=1 done=0",
                 name, j, cand, busy, done, to_bcd((s + j) % 10000));
      end
      @(negedge clk);
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || hit !== m_hit || cand !== to_bcd(m_final) ||
        result !== (m_hit ? target : 16'h0000) || attempts !== exp_attempts(m_cnt) || err !== 1'b0) begin
      failed++;
      $display("FAIL %s end: done=%b busy=%b hit=%b cand=%h result=%h att=%h err=%b, expected done=1 busy=0 hit=%b cand=%h result=%h att=%h err=0",
               name, done, busy, hit, cand, result, attempts, err,
               m_hit, to_bcd(m_final), m_hit ? target : 16'h0000, exp_attempts(m_cnt));
    end
    if (do_ack) begin
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      tests++;
      if (done !== 1'b0 || hit !== 1'b0 || busy !== 1'b0) begin
        failed++;
        $display("FAIL %s ack: done=%b hit=%b busy=%b, expected all 0", name, done, hit, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0;
    start_val = '0; end_val = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tests++;
    if (cand !== 16'h0 || result !== 16'h0 || attempts !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || hit !== 1'b0 || err !== 1'b0) begin
      failed++;
      $display("FAIL reset: cand=%h result=%h att=%h busy=%b done=%b hit=%b err=%b, expected all 0",
               cand, result, attempts, busy, done, hit, err);
    end
  endtask

  task automatic test_directed();
    target = 16'h0042;
    run_search(16'h0040, 16'h0099, 1'b1, "t1_hit");
    run_search(16'h0050, 16'h0060, 1'b1, "t2_miss");
    run_search(16'h9998, 16'h0001, 1'b1, "t3_wrap");
    run_search(16'h0042, 16'h0042, 1'b1, "t4_coincide");
  endtask

  task automatic test_err_abort();
    logic [15:0] held;
    held = cand;
    @(negedge clk);
    start = 1'b1; start_val = 16'h00A0; end_val = 16'h0099;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cand !== held) begin
      failed++;
      $display("FAIL err_start: err=%b busy=%b cand=%h, expected err=1 busy=0 cand=%h", err, busy, cand, held);
    end
    start = 1'b1; start_val = 16'h0010; end_val = 16'h9F00;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      failed++;
      $display("FAIL err_end: err=%b busy=%b, expected err=1 busy=0", err, busy);
    end
    @(negedge clk);
    tests++;
    if (err !== 1'b0) begin
      failed++;
      $display("FAIL err_pulse: err=%b, expected 0", err);
    end
    // Valid search; START during RUN must be ignored, ABORT in the 3rd RUN cycle.
    start = 1'b1; start_val = 16'h0050; end_val = 16'h0060;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; start_val = 16'h0010;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (cand !== 16'h0052 || busy !== 1'b1) begin
      failed++;
      $display("FAIL start_in_run: cand=%h busy=%b, expected cand=0052 busy=1", cand, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || hit !== 1'b0 || cand !== 16'h0052) begin
      failed++;
      $display("FAIL abort: busy=%b done=%b hit=%b cand=%h, expected 0 0 0 0052", busy, done, hit, cand);
    end
  endtask

  task automatic test_hold_and_ack();
    target = 16'h0042;
    run_search(16'h0041, 16'h0050, 1'b0, "hold_run");
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    tests++;
    if (done !== 1'b1 || hit !== 1'b1 || result !== 16'h0042 || cand !== 16'h0042) begin
      failed++;
      $display("FAIL abort_in_hit: done=%b hit=%b result=%h cand=%h, expected 1 1 0042 0042", done, hit, result, cand);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    tests++;
    if (done !== 1'b0 || hit !== 1'b0 || busy !== 1'b0 || result !== 16'h0042) begin
      failed++;
      $display("FAIL ack_idle: done=%b hit=%b busy=%b result=%h, expected 0 0 0 0042", done, hit, busy, result);
    end
  endtask

  task automatic test_rst_mid();
    target = 16'h0042;
    @(negedge clk);
    start = 1'b1; start_val = 16'h0040; end_val = 16'h0099;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    tests++;
    if (cand !== 16'h0041 || busy !== 1'b1) begin
      failed++;
      $display("FAIL rst_setup: cand=%h busy=%b, expected 0041 1", cand, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (cand !== 16'h0 || result !== 16'h0 || attempts !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || hit !== 1'b0 || err !== 1'b0) begin
      failed++;
      $display("FAIL rst_mid: cand=%h result=%h att=%h busy=%b done=%b hit=%b err=%b, expected all 0",
               cand, result, attempts, busy, done, hit, err);
    end
  endtask

  task automatic test_ack_start();
    run_search(16'h0040, 16'h0099, 1'b0, "ack_start_run");
    ack = 1'b1; start = 1'b1; start_val = 16'h0010; end_val = 16'h0020;
    @(negedge clk);
    ack = 1'b0; start = 1'b0;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0 || hit !== 1'b0 || cand !== 16'h0010 ||
        result !== 16'h0000 || attempts !== '0) begin
      failed++;
      $display("FAIL ack_start: busy=%b done=%b hit=%b cand=%h result=%h att=%h, expected 1 0 0 0010 0000 0",
               busy, done, hit, cand, result, attempts);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_back_to_back_random();
    int s, span, e, t;
    for (int k = 0; k < 24; k++) begin
      s    = int'($urandom_range(0, 9999));
      span = int'($urandom_range(0, 40));
      e    = (s + span) % 10000;
      if ($urandom_range(0, 1) == 1) t = (s + int'($urandom_range(0, span + 5))) % 10000;
      else                           t = int'($urandom_range(0, 9999));
      target = to_bcd(t);
      run_search(to_bcd(s), to_bcd(e), bit'($urandom_range(0, 1)), $sformatf("rand%0d", k));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_err_abort();
    test_hold_and_ack();
    test_rst_mid();
    test_ack_start();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
